// File: rtl/ppc_types.sv
// Shared PowerPC core types: condition/exception info and the result-bus record
// used by the arbiter, the ROB and the GPR writeback.
package ppc_types;

    localparam int unsigned RS_ID_WIDTH_DEFAULT = 5;

    typedef struct packed {
        logic [3:0] cr0;
        logic       so;
        logic       ov;
        logic       ca;
    } cond_exception_t;

    typedef struct packed {
        logic [RS_ID_WIDTH_DEFAULT-1:0] rs_id;
        logic [4:0]                     reg_addr;
        logic [31:0]                    result;
        cond_exception_t                cr0_xer;
    } result_bus_t;

endpackage

// File: rtl/result_bus_arbiter_pkg.sv
// Constants and helpers for the execution-unit result arbiter.
package result_bus_arbiter_pkg;

    localparam int unsigned UNITS_DEFAULT  = 4;
    localparam int unsigned GPR_ADDR_WIDTH = 5;
    localparam int unsigned RESULT_WIDTH   = 32;

    // Modulo-n increment that avoids a divider for non power-of-two n.
    function automatic int unsigned wrapIncrement(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/result_bus_arbiter_if.sv
// Execution-unit result ports plus the writeback / operand-broadcast side.
interface result_bus_arbiter_if
    import ppc_types::*;
#(
    parameter int unsigned UNITS       = 4,
    parameter int unsigned RS_ID_WIDTH = ppc_types::RS_ID_WIDTH_DEFAULT
) ();

    logic [UNITS-1:0]                  unit_valid;
    logic [UNITS-1:0]                  unit_ready;
    logic [UNITS-1:0][RS_ID_WIDTH-1:0] unit_rs_id;
    logic [UNITS-1:0][4:0]             unit_reg_addr;
    logic [UNITS-1:0][31:0]            unit_result;
    cond_exception_t [UNITS-1:0]       unit_cr0_xer;

    logic                              wb_valid;
    logic                              wb_ready;
    logic [4:0]                        wb_reg_addr;
    cond_exception_t                   wb_cr0_xer;
    logic                              update_op_valid;
    logic [RS_ID_WIDTH-1:0]            update_op_rs_id_out;
    logic [31:0]                       update_op_value_out;

    // Execution units and writeback drive the arbiter through this side.
    modport master (
        output unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, wb_ready,
        input  unit_ready, wb_valid, wb_reg_addr, wb_cr0_xer,
               update_op_valid, update_op_rs_id_out, update_op_value_out
    );

    modport slave (
        input  unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, wb_ready,
        output unit_ready, wb_valid, wb_reg_addr, wb_cr0_xer,
               update_op_valid, update_op_rs_id_out, update_op_value_out
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter: scans upward from the pointer, moves the pointer
// past the winner only when the caller reports that the grant was consumed.
module rr_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grantIdx_o,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int unsigned      cand;

    // First requester at or above the pointer, wrapping modulo N.
    always_comb begin
        grant_o    = '0;
        grantIdx_o = '0;
        found      = 1'b0;
        cand       = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr_q) + off) % N;
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                grant_o[cand]   = 1'b1;
                grantIdx_o      = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = PTR_W'(wrapIncrement(32'(grantIdx_o), N));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/result_bus_arbiter.sv
// Merges execution-unit results onto one registered result bus that feeds GPR
// writeback and broadcasts each result once to the reservation stations.
module result_bus_arbiter
    import ppc_types::*;
    import result_bus_arbiter_pkg::*;
#(
    parameter int unsigned UNITS       = UNITS_DEFAULT,
    parameter int unsigned RS_ID_WIDTH = RS_ID_WIDTH_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    result_bus_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (UNITS > 1) ? $clog2(UNITS) : 1;

    logic [UNITS-1:0]              grant;
    logic [IDX_W-1:0]              grantIdx;
    logic [IDX_W-1:0]              rrPtr;
    logic                          canLoad;
    logic                          transfer;

    logic                          wbValid_q,  wbValid_d;
    logic [RS_ID_WIDTH-1:0]        rsId_q,     rsId_d;
    logic [GPR_ADDR_WIDTH-1:0]     regAddr_q,  regAddr_d;
    logic [RESULT_WIDTH-1:0]       result_q,   result_d;
    cond_exception_t               cr0Xer_q,   cr0Xer_d;

    rr_arbiter #(
        .N (UNITS)
    ) u_rr (
        .clk        (clk),
        .rst        (rst),
        .req_i      (bus.unit_valid),
        .advance_i  (transfer),
        .grant_o    (grant),
        .grantIdx_o (grantIdx),
        .ptr_o      (rrPtr)
    );

    // The output stage can take a new result when empty or draining this cycle.
    always_comb begin
        canLoad        = !wbValid_q || bus.wb_ready;
        bus.unit_ready = rst ? '0 : (grant & {UNITS{canLoad}});
        transfer       = |(bus.unit_valid & bus.unit_ready);
    end

    always_comb begin
        wbValid_d = wbValid_q;
        rsId_d    = rsId_q;
        regAddr_d = regAddr_q;
        result_d  = result_q;
        cr0Xer_d  = cr0Xer_q;
        if (transfer) begin
            wbValid_d = 1'b1;
            rsId_d    = bus.unit_rs_id[grantIdx];
            regAddr_d = bus.unit_reg_addr[grantIdx];
            result_d  = bus.unit_result[grantIdx];
            cr0Xer_d  = bus.unit_cr0_xer[grantIdx];
        end else if (bus.wb_ready) begin
            wbValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbValid_q <= 1'b0;
            rsId_q    <= '0;
            regAddr_q <= '0;
            result_q  <= '0;
            cr0Xer_q  <= '0;
        end else begin
            wbValid_q <= wbValid_d;
            rsId_q    <= rsId_d;
            regAddr_q <= regAddr_d;
            result_q  <= result_d;
            cr0Xer_q  <= cr0Xer_d;
        end
    end

    // The broadcast is the writeback handshake itself, so each result fires once.
    always_comb begin
        bus.wb_valid            = wbValid_q;
        bus.wb_reg_addr         = regAddr_q;
        bus.wb_cr0_xer          = cr0Xer_q;
        bus.update_op_valid     = wbValid_q && bus.wb_ready;
        bus.update_op_rs_id_out = rsId_q;
        bus.update_op_value_out = result_q;
    end

    idlePointerHolds: assert property (@(posedge clk) disable iff (rst)
        !(|bus.unit_valid) |=> $stable(rrPtr));

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Self-checking bench for result_bus_arbiter: vector table, directed corner
// sequences and a random run, all checked against a queue-based scoreboard.
module tb_result_bus_arbiter;
    import ppc_types::*;

    localparam int UNITS = 4;
    localparam int RSW   = 5;

    typedef struct {
        logic [RSW-1:0]  rsId;
        logic [4:0]      regAddr;
        logic [31:0]     result;
        cond_exception_t cr0Xer;
    } expResult_t;

    typedef struct {
        logic [UNITS-1:0] valid;
        logic             wbReady;
        logic [UNITS-1:0] expReady;
        logic             expWbValid;
        logic             expUpdValid;
    } vector_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    result_bus_arbiter_if #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) bus ();

    result_bus_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    expResult_t      sbQueue[$];
    vector_t         vecTable[12];
    logic [RSW-1:0]  drvRsId   [UNITS];
    logic [4:0]      drvRegAddr[UNITS];
    logic [31:0]     drvResult [UNITS];
    cond_exception_t drvCr0Xer [UNITS];
    int              waitCount [UNITS];
    int              modelPtr;
    int              nVectors;
    int              nMiscompares;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model for one cycle: expected grant, output stage and broadcast.
    task automatic modelCycle();
        logic [UNITS-1:0] expReady;
        logic [UNITS-1:0] dutXfer;
        int               grantIdx;
        int               c;
        logic             canLoad;
        logic             fire;
        expResult_t       rec;
        grantIdx = -1;
        for (int off = 0; off < UNITS; off++) begin
            c = (modelPtr + off) % UNITS;
            if (grantIdx < 0 && bus.unit_valid[c]) grantIdx = c;
        end
        canLoad  = (sbQueue.size() == 0) || bus.wb_ready;
        expReady = '0;
        if (canLoad && grantIdx >= 0) expReady[grantIdx] = 1'b1;
        fire = (sbQueue.size() != 0) && bus.wb_ready;
        checkOutput("unit_ready", 64'(bus.unit_ready), 64'(expReady));
        checkOutput("wb_valid", 64'(bus.wb_valid), 64'(sbQueue.size() != 0));
        checkOutput("update_op_valid", 64'(bus.update_op_valid), 64'(fire));
        if (sbQueue.size() != 0) begin
            checkOutput("wb_reg_addr", 64'(bus.wb_reg_addr), 64'(sbQueue[0].regAddr));
            checkOutput("wb_cr0_xer", 64'(bus.wb_cr0_xer), 64'(sbQueue[0].cr0Xer));
            checkOutput("update_op_rs_id", 64'(bus.update_op_rs_id_out), 64'(sbQueue[0].rsId));
            checkOutput("update_op_value", 64'(bus.update_op_value_out), 64'(sbQueue[0].result));
        end
        if (fire) void'(sbQueue.pop_front());
        if (expReady != '0) begin
            rec.rsId    = drvRsId[grantIdx];
            rec.regAddr = drvRegAddr[grantIdx];
            rec.result  = drvResult[grantIdx];
            rec.cr0Xer  = drvCr0Xer[grantIdx];
            sbQueue.push_back(rec);
            modelPtr = (grantIdx + 1) % UNITS;
        end
        dutXfer = bus.unit_valid & bus.unit_ready;
        for (int i = 0; i < UNITS; i++) begin
            if (!bus.unit_valid[i] || dutXfer[i]) begin
                waitCount[i] = 0;
            end else if (dutXfer != '0) begin
                waitCount[i]++;
                checkOutput("wait_bound", 64'(waitCount[i] > UNITS), 64'(0));
            end
        end
    endtask

    task automatic applyStimulus(input logic [UNITS-1:0] valid, input logic wbReady);
        @(posedge clk);
        #2;
        bus.unit_valid = valid;
        bus.wb_ready   = wbReady;
        for (int i = 0; i < UNITS; i++) begin
            bus.unit_rs_id[i]    = drvRsId[i];
            bus.unit_reg_addr[i] = drvRegAddr[i];
            bus.unit_result[i]   = drvResult[i];
            bus.unit_cr0_xer[i]  = drvCr0Xer[i];
        end
        #1;
        modelCycle();
    endtask

    task automatic clearModel();
        sbQueue.delete();
        modelPtr = 0;
        for (int i = 0; i < UNITS; i++) waitCount[i] = 0;
    endtask

    initial begin
        logic [UNITS-1:0] curValid;
        nVectors     = 0;
        nMiscompares = 0;
        clearModel();
        for (int i = 0; i < UNITS; i++) begin
            drvRsId[i]    = 5'(8 + i);
            drvRegAddr[i] = 5'(16 + i);
            drvResult[i]  = 32'hA000_0000 + 32'(i);
            drvCr0Xer[i]  = cond_exception_t'(7'(3 * i + 1));
        end
        vecTable[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
        vecTable[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0};
        vecTable[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1};
        vecTable[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b0, 1'b0};
        vecTable[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecTable[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
        vecTable[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1};
        vecTable[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 1'b1};
        vecTable[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 1'b1};
        vecTable[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecTable[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1};
        vecTable[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};

        // Reset state, with units requesting so unit_ready must be masked.
        bus.unit_valid    = '1;
        bus.wb_ready      = 1'b1;
        bus.unit_rs_id    = '0;
        bus.unit_reg_addr = '0;
        bus.unit_result   = '0;
        bus.unit_cr0_xer  = '0;
        #3;
        checkOutput("rst_wb_valid", 64'(bus.wb_valid), 64'(0));
        checkOutput("rst_update_op_valid", 64'(bus.update_op_valid), 64'(0));
        checkOutput("rst_unit_ready", 64'(bus.unit_ready), 64'(0));
        bus.unit_valid = '0;
        @(posedge clk);
        #2 rst = 1'b0;

        // Table-driven vectors.
        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecTable[v].valid, vecTable[v].wbReady);
            checkOutput($sformatf("tbl%0d_ready", v), 64'(bus.unit_ready), 64'(vecTable[v].expReady));
            checkOutput($sformatf("tbl%0d_wb_valid", v), 64'(bus.wb_valid), 64'(vecTable[v].expWbValid));
            checkOutput($sformatf("tbl%0d_upd_valid", v), 64'(bus.update_op_valid), 64'(vecTable[v].expUpdValid));
        end

        // Single result from unit 2, visible one cycle after acceptance.
        drvRsId[2]    = 5'd5;
        drvRegAddr[2] = 5'd7;
        drvResult[2]  = 32'hDEAD_BEEF;
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_ready2", 64'(bus.unit_ready), 64'(4'b0100));
        applyStimulus(4'b0000, 1'b1);
        checkOutput("single_wb_valid", 64'(bus.wb_valid), 64'(1));
        checkOutput("single_upd_valid", 64'(bus.update_op_valid), 64'(1));
        checkOutput("single_rs_id", 64'(bus.update_op_rs_id_out), 64'(5));
        checkOutput("single_value", 64'(bus.update_op_value_out), 64'(32'hDEAD_BEEF));
        checkOutput("single_reg", 64'(bus.wb_reg_addr), 64'(7));

        // Reset while a result is held: discarded immediately, no broadcast.
        applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        bus.wb_ready = 1'b1;
        rst          = 1'b1;
        #1;
        checkOutput("midrst_wb_valid", 64'(bus.wb_valid), 64'(0));
        checkOutput("midrst_upd_valid", 64'(bus.update_op_valid), 64'(0));
        checkOutput("midrst_unit_ready", 64'(bus.unit_ready), 64'(0));
        clearModel();
        bus.unit_valid = '0;
        @(posedge clk);
        #2 rst = 1'b0;

        // Fairness: all units busy, grants rotate from unit 0 with no gaps.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 1'b1);
            checkOutput("rr_order", 64'(bus.unit_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                checkOutput("rr_tag", 64'(bus.update_op_rs_id_out), 64'(drvRsId[(k - 1) % 4]));
                checkOutput("rr_upd_valid", 64'(bus.update_op_valid), 64'(1));
            end
        end

        // Backpressure: unit 0's result is held for three cycles while unit 1 waits.
        applyStimulus(4'b0001, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0010, 1'b0);
            checkOutput("bp_ready", 64'(bus.unit_ready), 64'(0));
            checkOutput("bp_upd_valid", 64'(bus.update_op_valid), 64'(0));
            checkOutput("bp_rs_id", 64'(bus.update_op_rs_id_out), 64'(drvRsId[0]));
        end
        applyStimulus(4'b0010, 1'b1);
        checkOutput("bp_release_upd", 64'(bus.update_op_valid), 64'(1));
        checkOutput("bp_release_tag", 64'(bus.update_op_rs_id_out), 64'(drvRsId[0]));
        checkOutput("bp_release_ready", 64'(bus.unit_ready), 64'(4'b0010));
        applyStimulus(4'b0000, 1'b1);
        checkOutput("bp_next_tag", 64'(bus.update_op_rs_id_out), 64'(drvRsId[1]));

        // Pointer wrap: pointer at 3, units 0 and 3 requesting.
        applyStimulus(4'b0100, 1'b1);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("wrap_first", 64'(bus.unit_ready), 64'(4'b1000));
        applyStimulus(4'b0001, 1'b1);
        checkOutput("wrap_second", 64'(bus.unit_ready), 64'(4'b0001));
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);

        // Random traffic; a unit holds valid and data until it is accepted.
        curValid = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < UNITS; i++) begin
                if (!curValid[i] && $urandom_range(0, 1) == 1) begin
                    curValid[i]   = 1'b1;
                    drvRsId[i]    = 5'($urandom());
                    drvRegAddr[i] = 5'($urandom());
                    drvResult[i]  = $urandom();
                    drvCr0Xer[i]  = cond_exception_t'(7'($urandom()));
                end
            end
            applyStimulus(curValid, $urandom_range(0, 3) != 0);
            curValid = curValid & ~bus.unit_ready;
        end
        for (int k = 0; k < 3; k++) applyStimulus(4'b0000, 1'b1);
        checkOutput("sb_drained", 64'(sbQueue.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
